// File: rtl/matrix_column_scanner.sv
// matrix_column_scanner
//   Scans the columns of an LED/key matrix. Each scan position is driven
//   for DWELL cycles, followed by BLANK all-off cycles. A frame is NPOS
//   positions. In CONTINUOUS mode the scan wraps at the end of a frame.
//   Otherwise it returns to idle.
//
//   Optional feature: define COLUMN_SCANNER_MIRROR_EN for left/right mirrored
//   images. Position p then drives col[p] and col[COLS-1-p], and
//   NPOS = (COLS+1)/2.
//
// Parameters
//   COLS       physical columns (2..16)
//   DWELL      cycles each position is driven (1..255)
//   BLANK      all-off cycles between positions (0..15)
//   CONTINUOUS 1 = wrap and keep scanning, 0 = one frame then idle
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   pulse      start request (ignored while busy)
//   stop       synchronous abort to idle; has priority over pulse
//   col        registered column drive, active-high
//   pos        current scan position
//   busy       high while scanning or blanking
//   frame_done one-cycle pulse after the last position of a frame
module matrix_column_scanner #(
  parameter int unsigned COLS       = 5,
  parameter int unsigned DWELL      = 4,
  parameter int unsigned BLANK      = 1,
  parameter bit          CONTINUOUS = 1'b1,
`ifdef COLUMN_SCANNER_MIRROR_EN
  localparam int unsigned NPOS      = (COLS + 1) / 2,
`else
  localparam int unsigned NPOS      = COLS,
`endif
  localparam int unsigned IDX_W     = (NPOS > 1) ? $clog2(NPOS) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pulse,
  input  logic             stop,
  output logic [COLS-1:0]  col,
  output logic [IDX_W-1:0] pos,
  output logic             busy,
  output logic             frame_done
);

`ifdef COLUMN_SCANNER_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  // The dwell counter is sized for DWELL up to 255 (it counts 0..254).
  // The blank counter is sized for BLANK up to 15 (it counts 0..14).
  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0]       BLANK_LAST = (BLANK > 0) ? 4'(BLANK - 1) : 4'd0;
  localparam logic [IDX_W-1:0] LAST_POS   = IDX_W'(NPOS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_BLANK} state_t;

  state_t     state;
  logic [7:0] dcnt;
  logic [3:0] bcnt;

  logic scan_end;
  logic blank_end;
  logic advance;
  logic last_pos;

  // Column pattern for a scan position. In a mirrored build the mirrored
  // column is also set. For odd COLS both indices coincide at the centre.
  function automatic logic [COLS-1:0] pattern(input logic [IDX_W-1:0] p);
    logic [COLS-1:0] pat;
    pat = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      if ((i == 32'(p)) || (MIRROR && (i == (COLS - 1 - 32'(p)))))
        pat[i] = 1'b1;
    end
    return pat;
  endfunction

  // Without blanking, the advance happens directly from the last dwell cycle.
  // With blanking, the advance happens from the last blank cycle. The frame
  // therefore has no extra gap cycle at the wrap.
  always_comb begin
    scan_end  = (state == S_SCAN)  && (dcnt == DWELL_LAST);
    blank_end = (state == S_BLANK) && (bcnt == BLANK_LAST);
    advance   = (scan_end && (BLANK == 0)) || blank_end;
    last_pos  = (pos == LAST_POS);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      col        <= '0;
      pos        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dcnt       <= '0;
      bcnt       <= '0;
    end else begin
      frame_done <= 1'b0;
      if (stop) begin
        state <= S_IDLE;
        col   <= '0;
        pos   <= '0;
        busy  <= 1'b0;
        dcnt  <= '0;
        bcnt  <= '0;
      end else if (advance) begin
        dcnt <= '0;
        bcnt <= '0;
        if (!last_pos) begin
          state <= S_SCAN;
          pos   <= pos + IDX_W'(1);
          col   <= pattern(pos + IDX_W'(1));
          busy  <= 1'b1;
        end else begin
          frame_done <= 1'b1;
          pos        <= '0;
          if (CONTINUOUS) begin
            state <= S_SCAN;
            col   <= pattern('0);
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
            col   <= '0;
            busy  <= 1'b0;
          end
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (pulse) begin
              state <= S_SCAN;
              pos   <= '0;
              col   <= pattern('0);
              busy  <= 1'b1;
              dcnt  <= '0;
              bcnt  <= '0;
            end
          end
          S_SCAN: begin
            if (scan_end) begin
              // This branch is only reached when BLANK > 0.
              state <= S_BLANK;
              col   <= '0;
              dcnt  <= '0;
              bcnt  <= '0;
            end else begin
              dcnt <= dcnt + 8'd1;
            end
          end
          S_BLANK: begin
            bcnt <= bcnt + 4'd1;
          end
          default: begin
            state <= S_IDLE;
            col   <= '0;
            pos   <= '0;
            busy  <= 1'b0;
            dcnt  <= '0;
            bcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// Testbench for matrix_column_scanner. It uses two instances:
//   A: COLS=5, DWELL=2, BLANK=1, continuous
//   B: COLS=3, DWELL=1, BLANK=0, single frame
// The stimulus pushes the expected per-cycle outputs, tagged with a cycle
// number. A monitor compares them on the falling edge of that cycle.
module tb_matrix_column_scanner;

`ifdef COLUMN_SCANNER_MIRROR_EN
  localparam int A_PW    = 2;
  localparam int B_PW    = 1;
  localparam int A_FRAME = 9;
  localparam logic [4:0] A_COL [15] = '{5'h11, 5'h11, 5'h00, 5'h0A, 5'h0A, 5'h00,
                                        5'h04, 5'h04, 5'h00, 5'h00, 5'h00, 5'h00,
                                        5'h00, 5'h00, 5'h00};
  localparam logic [2:0] A_POS [15] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2,
                                        3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  localparam logic [2:0] B_COL [6]  = '{3'b101, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
  localparam logic [2:0] B_POS [6]  = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
  localparam logic       B_BSY [6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic       B_FD  [6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
  localparam int A_PW    = 3;
  localparam int B_PW    = 2;
  localparam int A_FRAME = 15;
  localparam logic [4:0] A_COL [15] = '{5'h01, 5'h01, 5'h00, 5'h02, 5'h02, 5'h00,
                                        5'h04, 5'h04, 5'h00, 5'h08, 5'h08, 5'h00,
                                        5'h10, 5'h10, 5'h00};
  localparam logic [2:0] A_POS [15] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2,
                                        3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4};
  localparam logic [2:0] B_COL [6]  = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000};
  localparam logic [2:0] B_POS [6]  = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0};
  localparam logic       B_BSY [6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic       B_FD  [6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`endif

  logic            clock;
  logic            reset_n;
  logic            pulse_a, stop_a, pulse_b, stop_b;
  logic [4:0]      col_a;
  logic [A_PW-1:0] pos_a;
  logic            busy_a, fd_a;
  logic [2:0]      col_b;
  logic [B_PW-1:0] pos_b;
  logic            busy_b, fd_b;

  matrix_column_scanner #(
    .COLS(5), .DWELL(2), .BLANK(1), .CONTINUOUS(1'b1)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .pulse(pulse_a), .stop(stop_a),
    .col(col_a), .pos(pos_a), .busy(busy_a), .frame_done(fd_a)
  );

  matrix_column_scanner #(
    .COLS(3), .DWELL(1), .BLANK(0), .CONTINUOUS(1'b0)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .pulse(pulse_b), .stop(stop_b),
    .col(col_b), .pos(pos_b), .busy(busy_b), .frame_done(fd_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    bit          is_b;
    logic [9:0]  v;     // {col[4:0], pos[2:0], busy, frame_done}
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got col/pos/busy/fd=%b expected %b", name, cyc, act, exp);
    end
  endtask

  function automatic void push_a(input int unsigned c, input int k, input string tag);
    exp_t e;
    int   m;
    m     = k % A_FRAME;
    e.cyc = c;
    e.is_b = 1'b0;
    e.v   = {A_COL[m], A_POS[m], 1'b1, ((k > 0) && (m == 0))};
    e.tag = tag;
    sb.push_back(e);
  endfunction

  function automatic void push_idle(input int unsigned c, input bit is_b, input string tag);
    exp_t e;
    e.cyc  = c;
    e.is_b = is_b;
    e.v    = '0;
    e.tag  = tag;
    sb.push_back(e);
  endfunction

  function automatic void push_b(input int unsigned c, input int k);
    exp_t e;
    e.cyc  = c;
    e.is_b = 1'b1;
    e.v    = {2'b00, B_COL[k], B_POS[k], B_BSY[k], B_FD[k]};
    e.tag  = "single_frame_b";
    sb.push_back(e);
  endfunction

  // Monitor: compares every expectation that is due in the current cycle.
  always @(negedge clock) begin
    exp_t       e;
    logic [9:0] act;
    while ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s: expectation for cyc %0d not compared (now %0d)", e.tag, e.cyc, cyc);
      end else begin
        if (e.is_b) act = {2'b00, col_b, 3'(pos_b), busy_b, fd_b};
        else        act = {col_a, 3'(pos_a), busy_a, fd_a};
        check(e.tag, act, e.v);
      end
    end
  end

  initial begin
    int unsigned c;
    int          n;
    pulse_a = 1'b0; stop_a = 1'b0; pulse_b = 1'b0; stop_b = 1'b0;
    reset_n = 1'b0;

    // Reset state is asserted with no clock edge yet.
    #1;
    check("reset_a", {col_a, 3'(pos_a), busy_a, fd_a}, 10'b0);
    check("reset_b", {2'b00, col_b, 3'(pos_b), busy_b, fd_b}, 10'b0);
    repeat (2) begin
      @(negedge clock);
      push_idle(cyc + 1, 1'b0, "in_reset_a");
      push_idle(cyc + 1, 1'b1, "in_reset_b");
    end
    // After reset is released, the block stays idle without a pulse.
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      push_idle(cyc + i, 1'b0, "post_reset_idle_a");
      push_idle(cyc + i, 1'b1, "post_reset_idle_b");
    end
    repeat (3) @(negedge clock);

    // Continuous scan with pulse held high throughout (no restart). Two frame wraps.
    c = cyc;
    pulse_a = 1'b1;
    for (int k = 0; k < 32; k++) push_a(c + 1 + k, k, "scan_pulse_held");
    repeat (32) @(negedge clock);
    pulse_a = 1'b0;
    stop_a  = 1'b1;
    push_idle(cyc + 1, 1'b0, "stop_in_scan");
    push_idle(cyc + 2, 1'b0, "stop_in_scan_hold");
    @(negedge clock);
    stop_a = 1'b0;
    @(negedge clock);

    // Stop in cycle 4 of a scan, then restart from position 0.
    c = cyc;
    pulse_a = 1'b1;
    for (int k = 0; k < 5; k++) push_a(c + 1 + k, k, "pre_stop");
    for (int k = 5; k < 8; k++) push_idle(c + 1 + k, 1'b0, "after_stop");
    @(negedge clock);
    pulse_a = 1'b0;
    repeat (4) @(negedge clock);
    stop_a = 1'b1;
    @(negedge clock);
    stop_a = 1'b0;
    repeat (2) @(negedge clock);
    c = cyc;
    pulse_a = 1'b1;
    for (int k = 0; k < 4; k++) push_a(c + 1 + k, k, "restart");
    @(negedge clock);
    pulse_a = 1'b0;
    repeat (3) @(negedge clock);
    stop_a = 1'b1;
    push_idle(cyc + 1, 1'b0, "stop_restart");
    @(negedge clock);
    stop_a = 1'b0;

    // Stop and pulse together while idle: stop wins.
    pulse_a = 1'b1;
    stop_a  = 1'b1;
    push_idle(cyc + 1, 1'b0, "stop_beats_pulse");
    push_idle(cyc + 2, 1'b0, "stop_beats_pulse");
    repeat (2) @(negedge clock);
    pulse_a = 1'b0;
    stop_a  = 1'b0;

    // Asynchronous reset in the middle of a scan.
    c = cyc;
    pulse_a = 1'b1;
    for (int k = 0; k < 4; k++) push_a(c + 1 + k, k, "pre_async_reset");
    @(negedge clock);
    pulse_a = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_a", {col_a, 3'(pos_a), busy_a, fd_a}, 10'b0);
    @(negedge clock);
    reset_n = 1'b1;
    pulse_a = 1'b1;
    stop_a  = 1'b1;
    push_idle(cyc + 1, 1'b0, "post_reset_stop_pulse");
    push_idle(cyc + 2, 1'b0, "post_reset_stop_pulse");
    repeat (2) @(negedge clock);
    pulse_a = 1'b0;
    stop_a  = 1'b0;

    // Reset released in the same cycle as pulse: the scan starts at the first edge.
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    pulse_a = 1'b1;
    c = cyc;
    for (int k = 0; k < 3; k++) push_a(c + 1 + k, k, "reset_release_pulse");
    @(negedge clock);
    pulse_a = 1'b0;
    repeat (2) @(negedge clock);
    stop_a = 1'b1;
    push_idle(cyc + 1, 1'b0, "stop_after_release");
    @(negedge clock);
    stop_a = 1'b0;

    // Single-frame instance: one frame, one frame_done, then idle.
    c = cyc;
    pulse_b = 1'b1;
    for (int k = 0; k < 6; k++) push_b(c + 1 + k, k);
    @(negedge clock);
    pulse_b = 1'b0;
    repeat (6) @(negedge clock);

    n = 0;
    while ((sb.size() > 0) && (n < 50)) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
